// File: rtl/big_core_pkg.sv
// Shared types and helpers for the big core's parametrised dual-port memory.
package big_core_pkg;

  // Clear engine / memory availability state.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } i_mem_state_t;

  // Deepest read pipeline the memory supports.
  localparam int I_MEM_MAX_RD_LAT = 3;

  // Read-during-write selection.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Overlay the enabled bytes of two same-cycle writes onto a word.
  // Port B is applied last so it wins on bytes both ports enable.
  function automatic logic [31:0] merge_word(
    input logic [31:0] old_word,
    input logic        a_hit,
    input logic [3:0]  a_be,
    input logic [31:0] a_data,
    input logic        b_hit,
    input logic [3:0]  b_be,
    input logic [31:0] b_data
  );
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < 4; i++) begin
      if (a_hit && a_be[i]) w[8*i +: 8] = a_data[8*i +: 8];
      if (b_hit && b_be[i]) w[8*i +: 8] = b_data[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/i_mem_rd_pipe.sv
// Read-data pipeline: RD_LAT stages of valid/data. Data stages only load
// when their incoming valid is set, so the last stage holds the most recent
// returned word while no read is completing.
module i_mem_rd_pipe
  import big_core_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (RD_LAT < 1) ? 1 :
                       (RD_LAT > I_MEM_MAX_RD_LAT) ? I_MEM_MAX_RD_LAT : RD_LAT;

  logic [LAT-1:0] valid_reg;
  logic [31:0]    data_reg [LAT];

  // Shift valid every cycle; move data only alongside a valid.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < LAT; i++) data_reg[i] <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      if (in_valid) data_reg[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (valid_reg[i-1]) data_reg[i] <= data_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[LAT-1];
  assign out_data  = data_reg[LAT-1];

endmodule

// File: rtl/i_mem_dp_param.sv
// Parametrised dual-port byte-enabled memory with a post-reset clear walk,
// same-word write collision merging and selectable read-during-write data.
module i_mem_dp_param
  import big_core_pkg::*;
#(
  parameter int WORDS          = 16384,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = RDW_OLD,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        rst_n,
  output logic        init_busy,
  input  logic        req_a,
  input  logic        wren_a,
  input  logic [29:0] address_a,
  input  logic [3:0]  byteen_a,
  input  logic [31:0] data_a,
  output logic [31:0] q_a,
  output logic        q_valid_a,
  input  logic        req_b,
  input  logic        wren_b,
  input  logic [29:0] address_b,
  input  logic [3:0]  byteen_b,
  input  logic [31:0] data_b,
  output logic [31:0] q_b,
  output logic        q_valid_b
);

  localparam int AW = $clog2(WORDS);
  localparam i_mem_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  // Word storage; deliberately not reset.
  logic [31:0] mem [WORDS];

  i_mem_state_t  state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          clear_we;
  logic          ready;

  logic [AW-1:0] idx_a, idx_b;
  logic          in_range_a, in_range_b;
  logic          wr_a, wr_b, rd_a, rd_b;
  logic [31:0]   rd_data_a, rd_data_b;

  assign ready     = (state_reg == S_READY);
  assign init_busy = (state_reg == S_CLEAR);

  // Low address bits index the array; upper bits only flag out-of-range.
  assign idx_a      = address_a[AW-1:0];
  assign idx_b      = address_b[AW-1:0];
  assign in_range_a = ((address_a >> AW) == '0);
  assign in_range_b = ((address_b >> AW) == '0);

  assign wr_a = ready && req_a && wren_a && in_range_a;
  assign wr_b = ready && req_b && wren_b && in_range_b;
  assign rd_a = ready && req_a && !wren_a;
  assign rd_b = ready && req_b && !wren_b;

  // Read word sampled at the accepting edge: pre-write or merged post-write.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (in_range_a) begin
      if (RDW_MODE == RDW_NEW)
        rd_data_a = merge_word(mem[idx_a], wr_a, byteen_a, data_a,
                               wr_b && (idx_b == idx_a), byteen_b, data_b);
      else
        rd_data_a = mem[idx_a];
    end
    if (in_range_b) begin
      if (RDW_MODE == RDW_NEW)
        rd_data_b = merge_word(mem[idx_b], wr_a && (idx_a == idx_b), byteen_a, data_a,
                               wr_b, byteen_b, data_b);
      else
        rd_data_b = mem[idx_b];
    end
  end

  // Array writes: clear walk, then port A bytes, then port B bytes (B wins).
  always_ff @(posedge clock) begin
    if (clear_we) mem[cnt_reg] <= '0;
    for (int i = 0; i < 4; i++) begin
      if (wr_a && byteen_a[i]) mem[idx_a][8*i +: 8] <= data_a[8*i +: 8];
      if (wr_b && byteen_b[i]) mem[idx_b][8*i +: 8] <= data_b[8*i +: 8];
    end
  end

  // Clear FSM state and walk counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Clear FSM next state: one word zeroed per cycle until the last word.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clear_we   = 1'b0;
    case (state_reg)
      S_CLEAR: begin
        clear_we = 1'b1;
        if (cnt_reg == AW'(WORDS - 1)) begin
          state_next = S_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_READY: begin
        state_next = S_READY;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  i_mem_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe_a (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (rd_a),
    .in_data   (rd_data_a),
    .out_valid (q_valid_a),
    .out_data  (q_a)
  );

  i_mem_rd_pipe #(.RD_LAT(RD_LAT)) u_pipe_b (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (rd_b),
    .in_data   (rd_data_b),
    .out_valid (q_valid_b),
    .out_data  (q_b)
  );

endmodule

// File: tb/tb_i_mem_dp_param.sv
// Directed bench: two 16-word RD_LAT=2 instances (old / new read-during-write)
// share stimulus; a third 32-word RD_LAT=3 instance without clear runs alone.
module tb_i_mem_dp_param;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic        req_a, wren_a, req_b, wren_b;
  logic [29:0] address_a, address_b;
  logic [3:0]  byteen_a, byteen_b;
  logic [31:0] data_a, data_b;

  logic        init_busy_0, q_valid_a_0, q_valid_b_0;
  logic [31:0] q_a_0, q_b_0;
  logic        init_busy_1, q_valid_a_1, q_valid_b_1;
  logic [31:0] q_a_1, q_b_1;

  logic        p2_req_a, p2_wren_a, p2_req_b, p2_wren_b;
  logic [29:0] p2_address_a, p2_address_b;
  logic [3:0]  p2_byteen_a, p2_byteen_b;
  logic [31:0] p2_data_a, p2_data_b;
  logic        init_busy_2, q_valid_a_2, q_valid_b_2;
  logic [31:0] q_a_2, q_b_2;

  int checks = 0;
  int fails  = 0;

  i_mem_dp_param #(.WORDS(16), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clock(clock), .rst_n(rst_n), .init_busy(init_busy_0),
    .req_a(req_a), .wren_a(wren_a), .address_a(address_a), .byteen_a(byteen_a),
    .data_a(data_a), .q_a(q_a_0), .q_valid_a(q_valid_a_0),
    .req_b(req_b), .wren_b(wren_b), .address_b(address_b), .byteen_b(byteen_b),
    .data_b(data_b), .q_b(q_b_0), .q_valid_b(q_valid_b_0)
  );

  i_mem_dp_param #(.WORDS(16), .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clock(clock), .rst_n(rst_n), .init_busy(init_busy_1),
    .req_a(req_a), .wren_a(wren_a), .address_a(address_a), .byteen_a(byteen_a),
    .data_a(data_a), .q_a(q_a_1), .q_valid_a(q_valid_a_1),
    .req_b(req_b), .wren_b(wren_b), .address_b(address_b), .byteen_b(byteen_b),
    .data_b(data_b), .q_b(q_b_1), .q_valid_b(q_valid_b_1)
  );

  i_mem_dp_param #(.WORDS(32), .RD_LAT(3), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .clock(clock), .rst_n(rst_n), .init_busy(init_busy_2),
    .req_a(p2_req_a), .wren_a(p2_wren_a), .address_a(p2_address_a), .byteen_a(p2_byteen_a),
    .data_a(p2_data_a), .q_a(q_a_2), .q_valid_a(q_valid_a_2),
    .req_b(p2_req_b), .wren_b(p2_wren_b), .address_b(p2_address_b), .byteen_b(p2_byteen_b),
    .data_b(p2_data_b), .q_b(q_b_2), .q_valid_b(q_valid_b_2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    req_a = 1'b0; wren_a = 1'b0; address_a = '0; byteen_a = '0; data_a = '0;
    req_b = 1'b0; wren_b = 1'b0; address_b = '0; byteen_b = '0; data_b = '0;
  endtask

  task automatic write_a(input logic [29:0] addr, input logic [3:0] be, input logic [31:0] d);
    req_a = 1'b1; wren_a = 1'b1; address_a = addr; byteen_a = be; data_a = d;
    tick;
    req_a = 1'b0; wren_a = 1'b0;
  endtask

  task automatic write_b(input logic [29:0] addr, input logic [3:0] be, input logic [31:0] d);
    req_b = 1'b1; wren_b = 1'b1; address_b = addr; byteen_b = be; data_b = d;
    tick;
    req_b = 1'b0; wren_b = 1'b0;
  endtask

  // Issue one read; v1 = any valid one cycle later, v2 = both valid at RD_LAT.
  task automatic read_a(input logic [29:0] addr, output logic v1, output logic v2,
                        output logic [31:0] q0, output logic [31:0] q1);
    req_a = 1'b1; wren_a = 1'b0; address_a = addr; byteen_a = 4'h0;
    tick;
    req_a = 1'b0;
    v1 = q_valid_a_0 | q_valid_a_1;
    tick;
    v2 = q_valid_a_0 & q_valid_a_1;
    q0 = q_a_0; q1 = q_a_1;
  endtask

  task automatic read_b(input logic [29:0] addr, output logic v1, output logic v2,
                        output logic [31:0] q0, output logic [31:0] q1);
    req_b = 1'b1; wren_b = 1'b0; address_b = addr; byteen_b = 4'h0;
    tick;
    req_b = 1'b0;
    v1 = q_valid_b_0 | q_valid_b_1;
    tick;
    v2 = q_valid_b_0 & q_valid_b_1;
    q0 = q_b_0; q1 = q_b_1;
  endtask

  // Count busy cycles (bounded) and any read-valid seen meanwhile.
  task automatic wait_clear(output int n, output int vld_seen);
    n = 0; vld_seen = 0;
    while ((init_busy_0 || init_busy_1) && n < 200) begin
      tick;
      n++;
      if (q_valid_a_0 | q_valid_a_1 | q_valid_b_0 | q_valid_b_1) vld_seen++;
    end
  endtask

  task automatic test_reset;
    idle;
    p2_req_a = 0; p2_wren_a = 0; p2_address_a = '0; p2_byteen_a = '0; p2_data_a = '0;
    p2_req_b = 0; p2_wren_b = 0; p2_address_b = '0; p2_byteen_b = '0; p2_data_b = '0;
    #2 rst_n = 1'b0;
    tick; tick;
    checks++;
    if (init_busy_0 !== 1'b1 || init_busy_1 !== 1'b1) begin
      fails++; $display("FAIL reset_busy: got %b/%b expected 1/1", init_busy_0, init_busy_1);
    end
    checks++;
    if (init_busy_2 !== 1'b0) begin
      fails++; $display("FAIL reset_busy_noclear: got %b expected 0", init_busy_2);
    end
    checks++;
    if (q_valid_a_0 !== 1'b0 || q_valid_b_1 !== 1'b0 || q_a_0 !== 32'h0 || q_b_1 !== 32'h0) begin
      fails++; $display("FAIL reset_outputs: got va=%b vb=%b qa=%h qb=%h expected all 0",
                        q_valid_a_0, q_valid_b_1, q_a_0, q_b_1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear;
    int n, v;
    logic v1, v2;
    logic [31:0] q0, q1;
    wait_clear(n, v);
    checks++;
    if (n != 16 || v != 0) begin
      fails++; $display("FAIL clear_cycles: got %0d busy, %0d valids expected 16, 0", n, v);
    end
    for (int i = 0; i < 16; i++) write_a(30'(i), 4'hF, 32'hFFFF_FFFF);
    read_a(30'd4, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'hFFFF_FFFF || q1 !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL preload: got v=%b %h/%h expected 1 ffffffff", v2, q0, q1);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    wait_clear(n, v);
    checks++;
    if (n != 16) begin
      fails++; $display("FAIL reclear_cycles: got %0d expected 16", n);
    end
    // Back-to-back reads of every word, one per cycle.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        req_a = 1'b1; wren_a = 1'b0; address_a = 30'(i);
      end else begin
        req_a = 1'b0;
      end
      tick;
      if (i >= 1) begin
        checks++;
        if (q_valid_a_0 !== 1'b1 || q_valid_a_1 !== 1'b1 || q_a_0 !== 32'h0 || q_a_1 !== 32'h0) begin
          fails++; $display("FAIL cleared_word%0d: got v=%b%b %h/%h expected 1 00000000",
                            i - 1, q_valid_a_0, q_valid_a_1, q_a_0, q_a_1);
        end
      end
    end
  endtask

  task automatic test_latency;
    logic v1, v2;
    logic [31:0] q0, q1;
    write_a(30'd5, 4'hF, 32'hDEAD_BEEF);
    read_a(30'd5, v1, v2, q0, q1);
    checks++;
    if (v1 !== 1'b0) begin
      fails++; $display("FAIL latency_early: got valid %b one cycle after request expected 0", v1);
    end
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'hDEAD_BEEF || q1 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL latency_data: got v=%b %h/%h expected 1 deadbeef", v2, q0, q1);
    end
    tick;
    checks++;
    if (q_valid_a_0 !== 1'b0 || q_a_0 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL latency_hold: got v=%b q=%h expected 0 deadbeef", q_valid_a_0, q_a_0);
    end
  endtask

  task automatic test_byte_enables;
    logic v1, v2;
    logic [31:0] q0, q1;
    write_a(30'd3, 4'hF, 32'h1122_3344);
    write_b(30'd3, 4'b0101, 32'hAABB_CCDD);
    read_a(30'd3, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h11BB_33DD || q1 !== 32'h11BB_33DD) begin
      fails++; $display("FAIL byteen_a: got v=%b %h/%h expected 1 11bb33dd", v2, q0, q1);
    end
    read_b(30'd3, v1, v2, q0, q1);
    checks++;
    if (v1 !== 1'b0 || v2 !== 1'b1 || q0 !== 32'h11BB_33DD || q1 !== 32'h11BB_33DD) begin
      fails++; $display("FAIL byteen_b: got v=%b%b %h/%h expected 01 11bb33dd", v1, v2, q0, q1);
    end
  endtask

  task automatic test_collision;
    logic v1, v2;
    logic [31:0] q0, q1;
    req_a = 1'b1; wren_a = 1'b1; address_a = 30'd7; byteen_a = 4'b0011; data_a = 32'h0000_FFFF;
    req_b = 1'b1; wren_b = 1'b1; address_b = 30'd7; byteen_b = 4'b0110; data_b = 32'h1234_5678;
    tick;
    idle;
    read_a(30'd7, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h0034_56FF || q1 !== 32'h0034_56FF) begin
      fails++; $display("FAIL collision: got v=%b %h/%h expected 1 003456ff", v2, q0, q1);
    end
  endtask

  task automatic test_rdw;
    logic v1, v2;
    logic [31:0] q0, q1;
    write_a(30'd9, 4'hF, 32'h0000_0001);
    req_a = 1'b1; wren_a = 1'b0; address_a = 30'd9;
    req_b = 1'b1; wren_b = 1'b1; address_b = 30'd9; byteen_b = 4'hF; data_b = 32'h0000_0002;
    tick;
    idle;
    tick;
    checks++;
    if (q_valid_a_0 !== 1'b1 || q_a_0 !== 32'h1) begin
      fails++; $display("FAIL rdw_old: got v=%b q=%h expected 1 00000001", q_valid_a_0, q_a_0);
    end
    checks++;
    if (q_valid_a_1 !== 1'b1 || q_a_1 !== 32'h2) begin
      fails++; $display("FAIL rdw_new: got v=%b q=%h expected 1 00000002", q_valid_a_1, q_a_1);
    end
    read_a(30'd9, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h2 || q1 !== 32'h2) begin
      fails++; $display("FAIL rdw_after: got v=%b %h/%h expected 1 00000002", v2, q0, q1);
    end
    // Port B reads while port A partially writes the same word.
    write_a(30'd10, 4'hF, 32'hAAAA_AAAA);
    req_a = 1'b1; wren_a = 1'b1; address_a = 30'd10; byteen_a = 4'b0001; data_a = 32'h0000_00BB;
    req_b = 1'b1; wren_b = 1'b0; address_b = 30'd10;
    tick;
    idle;
    tick;
    checks++;
    if (q_valid_b_0 !== 1'b1 || q_b_0 !== 32'hAAAA_AAAA || q_valid_b_1 !== 1'b1 || q_b_1 !== 32'hAAAA_AABB) begin
      fails++; $display("FAIL rdw_portb: got %b %h / %b %h expected 1 aaaaaaaa / 1 aaaaaabb",
                        q_valid_b_0, q_b_0, q_valid_b_1, q_b_1);
    end
  endtask

  task automatic test_out_of_range;
    logic v1, v2;
    logic [31:0] q0, q1;
    write_a(30'd0, 4'hF, 32'h55AA_55AA);
    write_a(30'd16, 4'hF, 32'hCAFE_F00D);
    read_a(30'd0, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h55AA_55AA || q1 !== 32'h55AA_55AA) begin
      fails++; $display("FAIL oor_write_dropped: got v=%b %h/%h expected 1 55aa55aa", v2, q0, q1);
    end
    read_a(30'd16, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h0 || q1 !== 32'h0) begin
      fails++; $display("FAIL oor_read16: got v=%b %h/%h expected 1 00000000", v2, q0, q1);
    end
    read_b(30'h2000_0000, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h0 || q1 !== 32'h0) begin
      fails++; $display("FAIL oor_read_high: got v=%b %h/%h expected 1 00000000", v2, q0, q1);
    end
  endtask

  task automatic test_reset_mid;
    int n, v;
    logic v1, v2;
    logic [31:0] q0, q1;
    read_a(30'd0, v1, v2, q0, q1);  // leaves 55aa55aa held on q_a
    req_a = 1'b1; wren_a = 1'b0; address_a = 30'd3;
    tick;
    req_a = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q_valid_a_0 !== 1'b0 || q_a_0 !== 32'h0 || q_valid_a_1 !== 1'b0 || q_a_1 !== 32'h0) begin
      fails++; $display("FAIL reset_inflight: got %b %h / %b %h expected 0 00000000",
                        q_valid_a_0, q_a_0, q_valid_a_1, q_a_1);
    end
    tick;
    rst_n = 1'b1;
    // Requests during clear must be ignored.
    req_a = 1'b1; wren_a = 1'b0; address_a = 30'd4;
    req_b = 1'b1; wren_b = 1'b1; address_b = 30'd4; byteen_b = 4'hF; data_b = 32'hFFFF_FFFF;
    wait_clear(n, v);
    idle;
    checks++;
    if (n != 16 || v != 0) begin
      fails++; $display("FAIL clear_after_inflight: got %0d busy, %0d valids expected 16, 0", n, v);
    end
    tick; tick;
    checks++;
    if (q_valid_a_0 | q_valid_a_1) begin
      fails++; $display("FAIL clear_read_dropped: got valid %b%b expected 00", q_valid_a_0, q_valid_a_1);
    end
    read_a(30'd4, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h0 || q1 !== 32'h0) begin
      fails++; $display("FAIL clear_write_dropped: got v=%b %h/%h expected 1 00000000", v2, q0, q1);
    end
    // Reset with the clear walk at cnt = 8.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (init_busy_0 !== 1'b1 || q_valid_a_0 !== 1'b0) begin
      fails++; $display("FAIL midclear_reset: got busy=%b v=%b expected 1 0", init_busy_0, q_valid_a_0);
    end
    tick;
    rst_n = 1'b1;
    wait_clear(n, v);
    checks++;
    if (n != 16) begin
      fails++; $display("FAIL midclear_restart: got %0d busy expected 16", n);
    end
    read_a(30'd16, v1, v2, q0, q1);
    checks++;
    if (v2 !== 1'b1 || q0 !== 32'h0 || q1 !== 32'h0) begin
      fails++; $display("FAIL post_reset_oor: got v=%b %h/%h expected 1 00000000", v2, q0, q1);
    end
  endtask

  task automatic test_lat3_noclear;
    logic early;
    checks++;
    if (init_busy_2 !== 1'b0) begin
      fails++; $display("FAIL noclear_busy: got %b expected 0", init_busy_2);
    end
    p2_req_a = 1'b1; p2_wren_a = 1'b1; p2_address_a = 30'd31; p2_byteen_a = 4'hF; p2_data_a = 32'h0BAD_C0DE;
    tick;
    p2_wren_a = 1'b0;  // read word 31 on A, out-of-range 32 on B
    p2_req_b = 1'b1; p2_wren_b = 1'b0; p2_address_b = 30'd32;
    tick;
    p2_req_a = 1'b0; p2_req_b = 1'b0;
    early = q_valid_a_2 | q_valid_b_2;
    tick;
    early = early | q_valid_a_2 | q_valid_b_2;
    checks++;
    if (early !== 1'b0) begin
      fails++; $display("FAIL lat3_early: got valid before 3 cycles expected none");
    end
    tick;
    checks++;
    if (q_valid_a_2 !== 1'b1 || q_a_2 !== 32'h0BAD_C0DE) begin
      fails++; $display("FAIL lat3_a: got v=%b q=%h expected 1 0badc0de", q_valid_a_2, q_a_2);
    end
    checks++;
    if (q_valid_b_2 !== 1'b1 || q_b_2 !== 32'h0) begin
      fails++; $display("FAIL lat3_b_oor: got v=%b q=%h expected 1 00000000", q_valid_b_2, q_b_2);
    end
    tick;
    checks++;
    if (q_valid_a_2 !== 1'b0 || q_a_2 !== 32'h0BAD_C0DE) begin
      fails++; $display("FAIL lat3_pulse: got v=%b q=%h expected 0 0badc0de", q_valid_a_2, q_a_2);
    end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_latency;
    test_byte_enables;
    test_collision;
    test_rdw;
    test_out_of_range;
    test_reset_mid;
    test_lat3_noclear;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i_mem_dp_param.md
Name: i_mem_dp_param

Overview:
- Parametrised dual-port, byte-addressable instruction/data memory; next generation of the core's fixed 32-bit synchronous instruction memory.
- Adds:
  - configurable depth and read latency
  - per-byte write enables
  - request/valid handshake
  - selectable read-during-write mode
  - defined same-word write collision priority
  - post-reset clear engine
- Sits between the fetch stage (port A) and the loader/debug or data path (port B) of the big core.

Parameters:
- WORDS, 16384, memory depth in 32-bit words; power of two, minimum 16.
- RD_LAT, 1, read latency in cycles from accepted read request to q_valid; legal values 1..3.
- RDW_MODE, 0, read-during-write to the same word: 0 returns old data, 1 returns new (merged) data.
- CLEAR_ON_RESET, 1, when 1 the memory is zeroed by an internal walk after reset deassertion.

Ports:
- clock  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- init_busy  out  1  high while the clear engine runs; requests are ignored while high.
- req_a  in  1  port A request strobe.
- wren_a  in  1  port A write when 1, read when 0.
- address_a  in  30  port A word address, bits [31:2].
- byteen_a  in  4  port A byte enables (bit i covers data[8i+7:8i]).
- data_a  in  32  port A write data.
- q_a  out  32  port A read data.
- q_valid_a  out  1  port A read-data-valid pulse.
- req_b, wren_b, address_b, byteen_b, data_b, q_b, q_valid_b: same as port A, for port B.

Behaviour:
- Reset (rst_n low, async):
  - q_a, q_b = 0; q_valid_a, q_valid_b = 0.
  - Read pipelines flushed.
  - Clear counter = 0.
  - init_busy = CLEAR_ON_RESET.
  - The memory array itself is not reset.
- FSM states: S_CLEAR, S_READY.
  - Reset enters S_CLEAR if CLEAR_ON_RESET=1, otherwise S_READY.
  - S_CLEAR: writes word[cnt] = 0, cnt++ each cycle. When cnt == WORDS-1 is written, go to S_READY.
  - init_busy is high for exactly WORDS cycles after rst_n rises.
  - Reset asserted mid-clear restarts at cnt=0.
- In S_CLEAR all requests are dropped: no write, no q_valid.
- Request acceptance: in S_READY, req_x=1 is accepted every cycle. There is no backpressure and a fully pipelined throughput of 1 request per port per cycle.
- Write (req & wren):
  - Bytes with byteen=1 are updated at the clock edge; other bytes are unchanged.
  - No q_valid is produced.
- Read (req & ~wren):
  - The word is sampled at the accepting edge, then delayed by RD_LAT-1 further register stages.
  - q_valid_x pulses high together with q_x, exactly RD_LAT cycles after the request cycle.
  - byteen is ignored on reads; the full word is returned.
- q_x holds its last value when q_valid_x is low.
- Out-of-range address (address >= WORDS): write is dropped; read returns 0 with a normal q_valid.
- Same-word write collision (A and B both write the same word in the same cycle):
  - Bytes enabled on both ports take port B data.
  - Bytes enabled on only one port take that port's data.
- Read-during-write (either port reads a word written in the same cycle by either port):
  - RDW_MODE=0: returns pre-write contents.
  - RDW_MODE=1: returns post-write merged contents, including collision resolution.
- Address arithmetic: only the low log2(WORDS) bits index the array. The upper bits are used solely for the out-of-range check.

Decomposition:
- Package big_core_pkg:
  - i_mem_state_t enum (S_CLEAR, S_READY)
  - I_MEM_MAX_RD_LAT = 3
  - RDW_OLD/RDW_NEW constants
- Sub-module i_mem_rd_pipe:
  - Parametrised RD_LAT-stage valid/data shift register with async active-low reset.
  - Instantiated once per port.
- Top module contains:
  - word array
  - collision/merge logic
  - clear FSM and counter

Test Plan:
- Clear after reset: WORDS=16, CLEAR_ON_RESET=1, preload array with 0xFFFFFFFF, release rst_n.
  - init_busy is high for 16 cycles.
  - A read of every address afterwards returns 0x00000000.
- Basic latency: RD_LAT=2. Port A writes 0xDEADBEEF to word 5, then reads word 5 in the next cycle.
  - q_valid_a is high exactly 2 cycles after the read request.
  - q_a = 0xDEADBEEF.
- Byte enables: word 3 = 0x11223344. Port B writes 0xAABBCCDD with byteen=4'b0101.
  - A subsequent read of word 3 returns 0x11BB33DD.
- Collision: same cycle, A writes 0x0000FFFF with byteen=4'b0011 and B writes 0x12345678 with byteen=4'b0110, both to word 7, initial value 0.
  - A subsequent read of word 7 returns 0x003456FF.
- Read-during-write: word 9 = 0x1. Same cycle, A reads word 9 while B writes 0x2 (byteen=4'hF).
  - RDW_MODE=0 returns 0x1; RDW_MODE=1 returns 0x2.
  - A following read returns 0x2 in both modes.
- Reset mid-operation: assert rst_n low when cnt=8 during clear, and with a read in flight in S_READY.
  - q_valid and q drop to 0 immediately.
  - The in-flight read never produces a valid.
  - init_busy is then high for a full WORDS cycles.
  - An out-of-range read (address=WORDS) returns 0 with q_valid.
